fifo_adc_apb_if: RTL

APB slave that drains the ADC sample FIFO and exposes it to the host. It sits directly downstream of `fifo_adc`: it samples the FIFO's fill level, overflow flag and head data, and issues single-cycle pop requests when the host reads the DATA register. It also provides a fill-level threshold interrupt, an overflow interrupt and a saturating overflow-event counter.

---
 rtl/fifo_adc_apb_if.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fifo_adc_apb_if.sv
// fifo_adc_apb_if
//   APB slave that drains the ADC sample FIFO. DATA reads return the FIFO head
//   and pop it in the same access cycle. Also provides sticky overflow/underrun
//   status, a fill-level threshold interrupt, an overflow interrupt and a
//   saturating count of overflow events.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   PADDR .. PENABLE    APB requester inputs (decode on PADDR[4:2])
//   PRDATA              read data, combinational during a read access, else 0
//   PREADY              always 1 (zero wait states)
//   PSLVERR             error for addresses 5..7 and writes to DATA/STATUS
//   fifo_fill_level_i   FIFO fill level, 0..2**W_FIFO
//   fifo_ovflw_i        FIFO overflow flag (level)
//   fifo_data_i         FIFO head entry
//   fifo_read_req_o     single-cycle pop request
//   irq_o               registered interrupt, active high
module fifo_adc_apb_if #(
    parameter int W_FIFO         = 4,
    parameter int W_DATA         = 32,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [W_FIFO:0]           fifo_fill_level_i,
    input  logic                      fifo_ovflw_i,
    input  logic [W_DATA-1:0]         fifo_data_i,
    output logic                      fifo_read_req_o,
    output logic                      irq_o
);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_CTRL    = 3'd2;
    localparam logic [2:0] A_IRQ     = 3'd3;
    localparam logic [2:0] A_OVF_CNT = 3'd4;

    logic [2:0]      addr;
    logic            access;
    logic            rd_access;
    logic            wr_access;
    logic            fifo_empty;
    logic            underrun;
    logic            slverr;
    logic            wr_ctrl;
    logic            wr_irq;
    logic            wr_cnt;
    logic            ovf_rise;
    logic            thr_hit;
    logic [31:0]     rdata;

    logic            irq_en_thr;
    logic            irq_en_ovf;
    logic [W_FIFO:0] threshold;
    logic [1:0]      pend;
    logic            sticky_ovf;
    logic            sticky_udr;
    logic [15:0]     ovf_cnt;
    logic            ovf_d;
    logic            irq;

    logic            unused_bits;
    assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0],
                           PWDATA[30:W_FIFO+9], PWDATA[7:2]};

    assign addr       = PADDR[4:2];
    assign access     = PSEL & PENABLE;
    assign rd_access  = access & ~PWRITE;
    assign wr_access  = access & PWRITE;
    assign fifo_empty = (fifo_fill_level_i == '0);
    assign underrun   = rd_access & (addr == A_DATA) & fifo_empty;
    assign slverr     = access & ((addr > A_OVF_CNT) |
                                  (PWRITE & (addr == A_DATA || addr == A_STATUS)));
    assign wr_ctrl    = wr_access & (addr == A_CTRL);
    assign wr_irq     = wr_access & (addr == A_IRQ);
    assign wr_cnt     = wr_access & (addr == A_OVF_CNT);
    assign ovf_rise   = fifo_ovflw_i & ~ovf_d;
    assign thr_hit    = (threshold != '0) & (fifo_fill_level_i >= threshold);

    // Read mux; everything outside a read access (including setup phase) is 0.
    always_comb begin
        rdata = '0;
        if (rd_access) begin
            case (addr)
                A_DATA: begin
                    if (!fifo_empty) rdata[W_DATA-1:0] = fifo_data_i;
                end
                A_STATUS: begin
                    rdata[W_FIFO:0] = fifo_fill_level_i;
                    rdata[16]       = fifo_ovflw_i;
                    rdata[17]       = sticky_ovf;
                    rdata[18]       = sticky_udr;
                end
                A_CTRL: begin
                    rdata[0]            = irq_en_thr;
                    rdata[1]            = irq_en_ovf;
                    rdata[W_FIFO+8:8]   = threshold;
                end
                A_IRQ:     rdata[1:0]  = pend;
                A_OVF_CNT: rdata[15:0] = ovf_cnt;
                default:   rdata = '0;
            endcase
        end
    end

    // Combinational outputs are forced inactive while reset is asserted so a
    // reset landing mid-access cannot pop the FIFO.
    assign PRDATA          = rst_n ? rdata : '0;
    assign PSLVERR         = rst_n & slverr;
    assign PREADY          = 1'b1;
    assign fifo_read_req_o = rst_n & rd_access & (addr == A_DATA) & ~fifo_empty;
    assign irq_o           = irq;

    // Clears are applied first so that a coincident set takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_thr <= 1'b0;
            irq_en_ovf <= 1'b0;
            threshold  <= '0;
            pend       <= '0;
            sticky_ovf <= 1'b0;
            sticky_udr <= 1'b0;
            ovf_cnt    <= '0;
            ovf_d      <= 1'b0;
            irq        <= 1'b0;
        end else begin
            ovf_d <= fifo_ovflw_i;
            irq   <= (irq_en_thr & pend[0]) | (irq_en_ovf & pend[1]);

            if (wr_ctrl) begin
                irq_en_thr <= PWDATA[0];
                irq_en_ovf <= PWDATA[1];
                threshold  <= PWDATA[W_FIFO+8:8];
            end

            if (wr_ctrl && PWDATA[31]) begin
                sticky_ovf <= 1'b0;
                sticky_udr <= 1'b0;
            end
            if (ovf_rise) sticky_ovf <= 1'b1;
            if (underrun) sticky_udr <= 1'b1;

            if (wr_irq)   pend    <= pend & ~PWDATA[1:0];
            if (thr_hit)  pend[0] <= 1'b1;
            if (ovf_rise) pend[1] <= 1'b1;

            if (ovf_rise) begin
                if (wr_cnt)                  ovf_cnt <= 16'd1;
                else if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            end else if (wr_cnt) begin
                ovf_cnt <= '0;
            end
        end
    end

endmodule
